imm_pipe_generator: RTL and testbench

Parametrised, pipelined successor to the combinational immediate generator. Decodes the instruction format, then extracts and sign-extends the immediate for all RV32I/RV64I formats (I, S, B, U, J, shift-amount, CSR zimm). The result passes through a configurable-depth elastic valid/ready pipeline with flush, plus a passthrough tag (typically the PC). It sits between fetch/decode and the execute operand muxes.

---
 rtl/imm_pkg.sv | 23 ++
 rtl/imm_format_decode.sv | 73 +++++++
 rtl/imm_pipe_generator.sv | 95 +++++++++
 tb/tb_imm_pipe_generator.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Opcode and immediate-format constants shared by the immediate decoder and its pipeline.
package imm_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] FMT_NONE  = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;
  localparam logic [2:0] FMT_CSRI  = 3'd7;

endpackage

// File: rtl/imm_format_decode.sv
// Combinational RV32I/RV64I immediate extraction: format code, extended immediate, illegal flag.
module imm_format_decode
  import imm_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [31:0]           inst,
  output logic [DATA_WIDTH-1:0] imm,
  output logic [2:0]            fmt,
  output logic                  illegal
);

  logic [6:0] opc;
  logic [2:0] funct3;

  assign opc    = inst[6:0];
  assign funct3 = inst[14:12];

  // Size casts of signed operands sign-extend to DATA_WIDTH; unsigned ones zero-extend.
  always_comb begin
    imm     = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    if (inst[1:0] != 2'b11) begin
      illegal = 1'b1;
    end else begin
      case (opc)
        OPC_LOAD, OPC_JALR: begin
          fmt = FMT_I;
          imm = DATA_WIDTH'($signed(inst[31:20]));
        end
        OPC_OPIMM: begin
          if (funct3 == 3'b001 || funct3 == 3'b101) begin
            fmt = FMT_SHAMT;
            if (DATA_WIDTH == 64) begin
              imm = DATA_WIDTH'(inst[25:20]);
            end else begin
              imm     = DATA_WIDTH'(inst[24:20]);
              illegal = inst[25];
            end
          end else begin
            fmt = FMT_I;
            imm = DATA_WIDTH'($signed(inst[31:20]));
          end
        end
        OPC_STORE: begin
          fmt = FMT_S;
          imm = DATA_WIDTH'($signed({inst[31:25], inst[11:7]}));
        end
        OPC_BRANCH: begin
          fmt = FMT_B;
          imm = DATA_WIDTH'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
        end
        OPC_LUI, OPC_AUIPC: begin
          fmt = FMT_U;
          imm = DATA_WIDTH'($signed({inst[31:12], 12'b0}));
        end
        OPC_JAL: begin
          fmt = FMT_J;
          imm = DATA_WIDTH'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
        end
        OPC_SYSTEM: begin
          if (funct3[2]) begin
            fmt = FMT_CSRI;
            imm = DATA_WIDTH'(inst[19:15]);
          end
        end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/imm_pipe_generator.sv
// Immediate generator: format decode followed by a PIPE_DEPTH-stage elastic valid/ready pipe with flush.
module imm_pipe_generator
  import imm_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PIPE_DEPTH = 2,
  parameter int TAG_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_inst,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_imm,
  output logic [2:0]            out_fmt,
  output logic                  out_illegal,
  output logic [TAG_WIDTH-1:0]  out_tag
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] imm;
    logic [2:0]            fmt;
    logic                  illegal;
    logic [TAG_WIDTH-1:0]  tag;
  } pay_t;

  pay_t                  in_pay;
  logic [PIPE_DEPTH-1:0] vld;
  pay_t                  pay [PIPE_DEPTH];
  logic [PIPE_DEPTH:0]   rdy;

  imm_format_decode #(.DATA_WIDTH(DATA_WIDTH)) u_dec (
    .inst    (in_inst),
    .imm     (in_pay.imm),
    .fmt     (in_pay.fmt),
    .illegal (in_pay.illegal)
  );
  assign in_pay.tag = in_tag;

  // Ready ripples back from the consumer so a full pipe still accepts when the tail drains.
  always_comb begin
    rdy             = '0;
    rdy[PIPE_DEPTH] = out_ready;
    for (int i = PIPE_DEPTH - 1; i >= 0; i--) begin
      rdy[i] = !vld[i] || rdy[i+1];
    end
  end

  for (genvar g = 0; g < PIPE_DEPTH; g++) begin : g_stage
    logic up_v;
    pay_t up_p;
    logic v_q;
    pay_t p_q;

    if (g == 0) begin : g_first
      assign up_v = in_valid;
      assign up_p = in_pay;
    end else begin : g_next
      assign up_v = vld[g-1];
      assign up_p = pay[g-1];
    end

    // Payload is reset so outputs read zero after reset; flush only kills valid bits.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
        p_q <= '0;
      end else begin
        if (flush) begin
          v_q <= 1'b0;
        end else if (rdy[g]) begin
          v_q <= up_v;
        end
        if (!flush && rdy[g] && up_v) begin
          p_q <= up_p;
        end
      end
    end

    assign vld[g] = v_q;
    assign pay[g] = p_q;
  end

  assign in_ready    = rdy[0];
  assign out_valid   = vld[PIPE_DEPTH-1];
  assign out_imm     = pay[PIPE_DEPTH-1].imm;
  assign out_fmt     = pay[PIPE_DEPTH-1].fmt;
  assign out_illegal = pay[PIPE_DEPTH-1].illegal;
  assign out_tag     = pay[PIPE_DEPTH-1].tag;

endmodule

// File: tb/tb_imm_pipe_generator.sv
// Directed bench for imm_pipe_generator: 32- and 64-bit instances side by side.
module tb_imm_pipe_generator;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_inst;
  logic [31:0] in_tag;

  logic        r32, v32, il32;
  logic [31:0] imm32, tag32;
  logic [2:0]  fmt32;
  logic        r64, v64, il64;
  logic [63:0] imm64;
  logic [31:0] tag64;
  logic [2:0]  fmt64;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  imm_pipe_generator #(.DATA_WIDTH(32), .PIPE_DEPTH(2), .TAG_WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r32),
    .in_inst(in_inst), .in_tag(in_tag), .out_valid(v32), .out_ready(out_ready),
    .out_imm(imm32), .out_fmt(fmt32), .out_illegal(il32), .out_tag(tag32));

  imm_pipe_generator #(.DATA_WIDTH(64), .PIPE_DEPTH(2), .TAG_WIDTH(32)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r64),
    .in_inst(in_inst), .in_tag(in_tag), .out_valid(v64), .out_ready(out_ready),
    .out_imm(imm64), .out_fmt(fmt64), .out_illegal(il64), .out_tag(tag64));

  typedef struct {
    logic [31:0] inst;
    logic [2:0]  fmt;
    logic [31:0] imm_32;
    logic        ill_32;
    logic [63:0] imm_64;
    logic        ill_64;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    vecs[0]  = '{32'hFFF00093, 3'd1, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    vecs[1]  = '{32'hFE000EE3, 3'd3, 32'hFFFFFFFC, 1'b0, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[2]  = '{32'h800000B7, 3'd4, 32'h80000000, 1'b0, 64'hFFFFFFFF80000000, 1'b0};
    vecs[3]  = '{32'h123450B7, 3'd4, 32'h12345000, 1'b0, 64'h0000000012345000, 1'b0};
    vecs[4]  = '{32'h0000007F, 3'd0, 32'h00000000, 1'b1, 64'h0000000000000000, 1'b1};
    vecs[5]  = '{32'h02009093, 3'd6, 32'h00000000, 1'b1, 64'h0000000000000020, 1'b0};
    vecs[6]  = '{32'hFE112C23, 3'd2, 32'hFFFFFFF8, 1'b0, 64'hFFFFFFFFFFFFFFF8, 1'b0};
    vecs[7]  = '{32'h0080006F, 3'd5, 32'h00000008, 1'b0, 64'h0000000000000008, 1'b0};
    vecs[8]  = '{32'hFFDFF06F, 3'd5, 32'hFFFFFFFC, 1'b0, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[9]  = '{32'h300FD073, 3'd7, 32'h0000001F, 1'b0, 64'h000000000000001F, 1'b0};
    vecs[10] = '{32'h00000073, 3'd0, 32'h00000000, 1'b0, 64'h0000000000000000, 1'b0};
    vecs[11] = '{32'h7FF02083, 3'd1, 32'h000007FF, 1'b0, 64'h00000000000007FF, 1'b0};
    vecs[12] = '{32'hFFF00091, 3'd0, 32'h00000000, 1'b1, 64'h0000000000000000, 1'b1};
    vecs[13] = '{32'hFFFFF097, 3'd4, 32'hFFFFF000, 1'b0, 64'hFFFFFFFFFFFFF000, 1'b0};
    vecs[14] = '{32'h41F0D093, 3'd6, 32'h0000001F, 1'b0, 64'h000000000000001F, 1'b0};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_inst = 32'h0; in_tag = 32'h0;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_valid32", 64'(v32), 64'd0);
    chk("rst_ready32", 64'(r32), 64'd1);
    chk("rst_imm64", imm64, 64'd0);
    chk("rst_ready64", 64'(r64), 64'd1);

    // Single-instruction latency: accepted on edge 1, visible after edge 2.
    for (int i = 0; i < NV; i++) begin
      in_inst = vecs[i].inst; in_tag = 32'h100 + 32'(i); in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk($sformatf("v%0d_early32", i), 64'(v32), 64'd0);
      step();
      chk($sformatf("v%0d_valid32", i), 64'(v32), 64'd1);
      chk($sformatf("v%0d_imm32", i), 64'(imm32), 64'(vecs[i].imm_32));
      chk($sformatf("v%0d_fmt32", i), 64'(fmt32), 64'(vecs[i].fmt));
      chk($sformatf("v%0d_ill32", i), 64'(il32), 64'(vecs[i].ill_32));
      chk($sformatf("v%0d_tag32", i), 64'(tag32), 64'h100 + 64'(i));
      chk($sformatf("v%0d_valid64", i), 64'(v64), 64'd1);
      chk($sformatf("v%0d_imm64", i), imm64, vecs[i].imm_64);
      chk($sformatf("v%0d_fmt64", i), 64'(fmt64), 64'(vecs[i].fmt));
      chk($sformatf("v%0d_ill64", i), 64'(il64), 64'(vecs[i].ill_64));
      step();
      chk($sformatf("v%0d_drain32", i), 64'(v32), 64'd0);
    end

    // Backpressure: two entries fill the pipe, third waits, then all drain in order.
    out_ready = 1'b0; in_inst = 32'hFFF00093;
    in_valid = 1'b1; in_tag = 32'd1;
    step();
    chk("bp_ready_after1", 64'(r32), 64'd1);
    in_tag = 32'd2;
    step();
    chk("bp_ready_full", 64'(r32), 64'd0);
    chk("bp_valid_full", 64'(v32), 64'd1);
    chk("bp_tag_head", 64'(tag32), 64'd1);
    in_tag = 32'd3;
    step(); step();
    chk("bp_tag_held", 64'(tag32), 64'd1);
    chk("bp_ready_held", 64'(r32), 64'd0);
    out_ready = 1'b1;
    #1;
    chk("bp_ready_nobubble", 64'(r32), 64'd1);
    step();
    in_valid = 1'b0;
    chk("bp_out2_valid", 64'(v32), 64'd1);
    chk("bp_out2_tag", 64'(tag32), 64'd2);
    step();
    chk("bp_out3_valid", 64'(v32), 64'd1);
    chk("bp_out3_tag", 64'(tag32), 64'd3);
    chk("bp_out3_tag64", 64'(tag64), 64'd3);
    step();
    chk("bp_empty", 64'(v32), 64'd0);

    // Flush on a full pipe with a concurrent input: everything is dropped.
    out_ready = 1'b0; in_valid = 1'b1; in_tag = 32'd10;
    step();
    in_tag = 32'd11;
    step();
    chk("fl_full_valid", 64'(v32), 64'd1);
    flush = 1'b1; in_tag = 32'd12;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid32", 64'(v32), 64'd0);
    chk("fl_valid64", 64'(v64), 64'd0);
    chk("fl_ready", 64'(r32), 64'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("fl_nothing_%0d", k), 64'(v32), 64'd0);
    end

    // Asynchronous reset while a result is stalled at the output.
    out_ready = 1'b0; in_inst = 32'hFFF00093; in_tag = 32'h55; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("ar_pre_valid", 64'(v32), 64'd1);
    chk("ar_pre_imm", 64'(imm32), 64'hFFFFFFFF);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid32", 64'(v32), 64'd0);
    chk("ar_imm32", 64'(imm32), 64'd0);
    chk("ar_fmt32", 64'(fmt32), 64'd0);
    chk("ar_ill32", 64'(il32), 64'd0);
    chk("ar_tag32", 64'(tag32), 64'd0);
    chk("ar_imm64", imm64, 64'd0);
    chk("ar_valid64", 64'(v64), 64'd0);
    step();
    rst = 1'b0;
    #1;
    chk("ar_ready_after", 64'(r32), 64'd1);
    chk("ar_valid_after", 64'(v32), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
